tcp_syn_initiator: RTL

//  Active-open side of the TCP three-way handshake in the pkt_parser NoC design. On start it emits a

---
 rtl/tcp_syn_initiator_pkg.sv | 70 +++++++
 rtl/avalonst_if.sv | 22 ++
 rtl/tcp_syn_initiator_hdr_build.sv | 32 +++
 rtl/tcp_syn_initiator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_syn_initiator_pkg.sv
// Shared types, beat field offsets and TCP constants for the
// active-open handshake block.
package tcp_syn_initiator_pkg;

    localparam int unsigned DATA_W  = 512;
    localparam int unsigned EMPTY_W = 6;

    typedef struct packed {
        logic               valid;
        logic               sop;
        logic               eop;
        logic               error;
        logic [DATA_W-1:0]  data;
        logic [EMPTY_W-1:0] empty;
    } avalonst_t;

    // MSB index of each field inside the single-beat frame
    localparam int unsigned OFF_DST_MAC  = 511;
    localparam int unsigned OFF_SRC_MAC  = 463;
    localparam int unsigned OFF_ETHTYPE  = 415;
    localparam int unsigned OFF_IP_VIT   = 399;
    localparam int unsigned OFF_IP_LEN   = 383;
    localparam int unsigned OFF_IP_IDF   = 367;
    localparam int unsigned OFF_IP_TTL   = 335;
    localparam int unsigned OFF_IP_PROTO = 327;
    localparam int unsigned OFF_IP_CSUM  = 319;
    localparam int unsigned OFF_SRC_IP   = 303;
    localparam int unsigned OFF_DST_IP   = 271;
    localparam int unsigned OFF_SRC_PORT = 239;
    localparam int unsigned OFF_DST_PORT = 223;
    localparam int unsigned OFF_SEQ      = 207;
    localparam int unsigned OFF_ACK      = 175;
    localparam int unsigned OFF_FLAGS    = 143;

    localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] IP_VIT       = 16'h4500;
    localparam logic [15:0] IP_LEN       = 16'd40;
    localparam logic [31:0] IP_IDF       = 32'h0000_4000;
    localparam logic [7:0]  IP_TTL       = 8'd10;
    localparam logic [7:0]  IP_PROTO_TCP = 8'h06;

    localparam logic [15:0] TCP_FLAG_SYN = 16'h0002;
    localparam logic [15:0] TCP_FLAG_ACK = 16'h0010;
    localparam int unsigned FLAG_BIT_SYN = 1;
    localparam int unsigned FLAG_BIT_ACK = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_SYN,
        ST_WAIT_SYNACK,
        ST_SEND_ACK,
        ST_ESTABLISHED,
        ST_FAILED
    } tcp_init_state_e;

    typedef struct packed {
        logic [47:0] local_mac;
        logic [47:0] peer_mac;
        logic [31:0] local_ip;
        logic [31:0] peer_ip;
        logic [15:0] local_port;
        logic [15:0] peer_port;
    } tcp_ep_t;

    typedef struct packed {
        tcp_ep_t     ep;
        logic [31:0] isn;
    } tcp_cfg_t;

endpackage

// File: rtl/avalonst_if.sv
// Avalon-ST style packet stream: 512b data, 6b empty, valid/ready.
interface avalonst_if;

    logic         valid;
    logic         ready;
    logic         sop;
    logic         eop;
    logic         error;
    logic [511:0] data;
    logic [5:0]   empty;

    modport src (
        output valid, sop, eop, error, data, empty,
        input  ready
    );

    modport sink (
        input  valid, sop, eop, error, data, empty,
        output ready
    );

endinterface

// File: rtl/tcp_syn_initiator_hdr_build.sv
// Combinational Ethernet/IPv4/TCP beat builder for SYN and ACK frames.
module tcp_hdr_build
    import tcp_syn_initiator_pkg::*;
(
    input  tcp_ep_t            ep,
    input  logic [31:0]        seq,
    input  logic [31:0]        ack,
    input  logic [15:0]        flags,
    output logic [DATA_W-1:0]  data
);

    always_comb begin
        data = '0;
        data[OFF_DST_MAC  -: 48] = ep.peer_mac;
        data[OFF_SRC_MAC  -: 48] = ep.local_mac;
        data[OFF_ETHTYPE  -: 16] = ETHTYPE_IPV4;
        data[OFF_IP_VIT   -: 16] = IP_VIT;
        data[OFF_IP_LEN   -: 16] = IP_LEN;
        data[OFF_IP_IDF   -: 32] = IP_IDF;
        data[OFF_IP_TTL   -: 8]  = IP_TTL;
        data[OFF_IP_PROTO -: 8]  = IP_PROTO_TCP;
        data[OFF_IP_CSUM  -: 16] = 16'h0000;
        data[OFF_SRC_IP   -: 32] = ep.local_ip;
        data[OFF_DST_IP   -: 32] = ep.peer_ip;
        data[OFF_SRC_PORT -: 16] = ep.local_port;
        data[OFF_DST_PORT -: 16] = ep.peer_port;
        data[OFF_SEQ      -: 32] = seq;
        data[OFF_ACK      -: 32] = ack;
        data[OFF_FLAGS    -: 16] = flags;
    end

endmodule

// File: rtl/tcp_syn_initiator.sv
// Active-open TCP handshake: sends SYN, matches SYN-ACK, sends ACK,
// retries the SYN on timeout and gives up after MAX_RETRIES resends.
module tcp_syn_initiator
    import tcp_syn_initiator_pkg::*;
#(
    parameter int unsigned NOC_RADIX      = 16,
    parameter int unsigned NUM_VC         = 2,
    parameter int unsigned DEST_NODE      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    avalonst_if.src                      out,
    avalonst_if.sink                     in_reply,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [47:0]                  i_local_mac,
    input  logic [47:0]                  i_peer_mac,
    input  logic [31:0]                  i_local_ip,
    input  logic [31:0]                  i_peer_ip,
    input  logic [15:0]                  i_local_port,
    input  logic [15:0]                  i_peer_port,
    input  logic [31:0]                  i_isn,
    output logic [$clog2(NOC_RADIX)-1:0] o_noc_dst,
    output logic [$clog2(NUM_VC)-1:0]    o_vc_id,
    output logic                         o_established,
    output logic                         o_failed,
    output logic [31:0]                  o_peer_seq,
    output logic [15:0]                  o_drop_cnt
);

    localparam int unsigned DST_W = $clog2(NOC_RADIX);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] RETRY_MAX = 16'(MAX_RETRIES);

    tcp_init_state_e    state_q, state_d;
    tcp_cfg_t           cfg_q, cfg_d;
    avalonst_t          beat_q, beat_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
    logic [15:0]        retry_q, retry_d;
    logic [31:0]        peer_seq_q, peer_seq_d;
    logic [15:0]        drop_q, drop_d;

    logic               start_ok;
    logic               accept;
    logic               in_send;
    logic               in_wait;
    logic               match;
    logic               timeout;
    logic               retry_ok;
    logic               send_ack;
    logic [31:0]        tx_seq;
    logic [31:0]        tx_ack;
    logic [15:0]        tx_flags;
    logic [DATA_W-1:0]  tx_data;

    logic [15:0]        r_ethtype;
    logic [7:0]         r_proto;
    logic [15:0]        r_sport;
    logic [15:0]        r_dport;
    logic [31:0]        r_seq;
    logic [31:0]        r_ack;
    logic [15:0]        r_flags;
    logic               unused_reply;

    assign start_ok = i_start
        && (state_q == ST_IDLE || state_q == ST_FAILED);
    assign accept   = beat_q.valid && out.ready;
    assign in_send  = (state_q == ST_SEND_SYN)
        || (state_q == ST_SEND_ACK);
    assign in_wait  = (state_q == ST_WAIT_SYNACK);
    assign send_ack = (state_q == ST_SEND_ACK);

    assign r_ethtype = in_reply.data[OFF_ETHTYPE  -: 16];
    assign r_proto   = in_reply.data[OFF_IP_PROTO -: 8];
    assign r_sport   = in_reply.data[OFF_SRC_PORT -: 16];
    assign r_dport   = in_reply.data[OFF_DST_PORT -: 16];
    assign r_seq     = in_reply.data[OFF_SEQ      -: 32];
    assign r_ack     = in_reply.data[OFF_ACK      -: 32];
    assign r_flags   = in_reply.data[OFF_FLAGS    -: 16];
    assign unused_reply = ^{in_reply.data, in_reply.error,
                            in_reply.empty};

    assign match = in_wait
        && in_reply.valid && in_reply.sop && in_reply.eop
        && (r_ethtype == ETHTYPE_IPV4)
        && (r_proto == IP_PROTO_TCP)
        && (r_sport == cfg_q.ep.peer_port)
        && (r_dport == cfg_q.ep.local_port)
        && r_flags[FLAG_BIT_ACK] && r_flags[FLAG_BIT_SYN]
        && (r_ack == cfg_q.isn + 32'd1);

    // Timer reads 0 on the first WAIT cycle; WAIT lasts TIMEOUT_CYCLES-1 cycles
    assign tmo_inc  = tmo_q + TMO_W'(1);
    assign timeout  = in_wait && (tmo_inc == TMO_LAST);
    assign retry_ok = (retry_q < RETRY_MAX);

    assign tx_seq   = send_ack ? cfg_q.isn + 32'd1 : cfg_q.isn;
    assign tx_ack   = send_ack ? peer_seq_q + 32'd1 : 32'd0;
    assign tx_flags = send_ack ? TCP_FLAG_ACK : TCP_FLAG_SYN;

    tcp_hdr_build u_hdr (
        .ep    (cfg_q.ep),
        .seq   (tx_seq),
        .ack   (tx_ack),
        .flags (tx_flags),
        .data  (tx_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_FAILED: begin
                    if (i_start) state_d = ST_SEND_SYN;
                end
                ST_SEND_SYN: begin
                    if (accept) state_d = ST_WAIT_SYNACK;
                end
                ST_WAIT_SYNACK: begin
                    if (match) begin
                        state_d = ST_SEND_ACK;
                    end else if (timeout) begin
                        state_d = retry_ok ? ST_SEND_SYN : ST_FAILED;
                    end
                end
                ST_SEND_ACK: begin
                    if (accept) state_d = ST_ESTABLISHED;
                end
                ST_ESTABLISHED: state_d = ST_ESTABLISHED;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_established = (state_q == ST_ESTABLISHED);
        o_failed      = (state_q == ST_FAILED);
        o_noc_dst     = beat_q.valid ? DST_W'(DEST_NODE) : '0;
    end

    always_comb begin
        cfg_d      = cfg_q;
        retry_d    = retry_q;
        tmo_d      = '0;
        peer_seq_d = peer_seq_q;
        drop_d     = drop_q;
        beat_d     = beat_q;

        if (in_wait) tmo_d = tmo_inc;
        if (match) peer_seq_d = r_seq;
        if (in_reply.valid && !match && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end

        if (!i_abort && start_ok) begin
            cfg_d.ep.local_mac  = i_local_mac;
            cfg_d.ep.peer_mac   = i_peer_mac;
            cfg_d.ep.local_ip   = i_local_ip;
            cfg_d.ep.peer_ip    = i_peer_ip;
            cfg_d.ep.local_port = i_local_port;
            cfg_d.ep.peer_port  = i_peer_port;
            cfg_d.isn           = i_isn;
            retry_d             = '0;
        end
        if (!i_abort && timeout && !match && retry_ok) begin
            retry_d = retry_q + 16'd1;
        end

        // Abort discards an in-flight beat even if it is not yet accepted
        if (i_abort || accept) begin
            beat_d = '0;
        end else if (in_send && !beat_q.valid) begin
            beat_d.valid = 1'b1;
            beat_d.sop   = 1'b1;
            beat_d.eop   = 1'b1;
            beat_d.error = 1'b0;
            beat_d.empty = '0;
            beat_d.data  = tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q      <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            peer_seq_q <= '0;
            drop_q     <= '0;
            beat_q     <= '0;
        end else begin
            cfg_q      <= cfg_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            peer_seq_q <= peer_seq_d;
            drop_q     <= drop_d;
            beat_q     <= beat_d;
        end
    end

    assign out.valid      = beat_q.valid;
    assign out.sop        = beat_q.sop;
    assign out.eop        = beat_q.eop;
    assign out.error      = beat_q.error;
    assign out.data       = beat_q.data;
    assign out.empty      = beat_q.empty;
    assign in_reply.ready = 1'b1;
    assign o_vc_id        = '0;
    assign o_peer_seq     = peer_seq_q;
    assign o_drop_cnt     = drop_q;

endmodule
